// File: rtl/program_loader.sv
// Byte-stream program loader: assembles big-endian 16-bit words from a byte stream,
// writes them to sequential program-memory addresses, then checks a trailing XOR byte.
module program_loader #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Start,
    input  logic [ADDR_W:0]   Word_Count,
    input  logic [7:0]        Rx_Data,
    input  logic              Rx_Valid,
    output logic              Wr_En,
    output logic [ADDR_W-1:0] Wr_Addr,
    output logic [DATA_W-1:0] Wr_Data,
    output logic              Busy,
    output logic              Done,
    output logic              Chk_Ok,
    output logic [2:0]        o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HI   = 3'd1,
        S_LO   = 3'd2,
        S_CHK  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] L_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] L_ONE = (ADDR_W + 1)'(1);

    state_t              r_state;
    logic [ADDR_W:0]     r_n;
    logic [ADDR_W:0]     r_cnt;
    logic [7:0]          r_hi;
    logic [7:0]          r_acc;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_busy;
    logic                r_done;
    logic                r_chk_ok;

    logic [ADDR_W:0]     w_n;
    logic [ADDR_W:0]     w_cnt_next;
    logic [7:0]          w_acc_next;

    // Requests beyond the memory depth are clipped so the address can never wrap.
    assign w_n        = (Word_Count > L_MAX) ? L_MAX : Word_Count;
    assign w_cnt_next = r_cnt + L_ONE;
    assign w_acc_next = r_acc ^ Rx_Data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_n       <= '0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_acc     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_chk_ok  <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        r_n       <= w_n;
                        r_cnt     <= '0;
                        r_acc     <= '0;
                        r_wr_addr <= '0;
                        if (w_n == '0) begin
                            r_state  <= S_DONE;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_chk_ok <= 1'b1;
                        end else begin
                            r_state  <= S_HI;
                            r_busy   <= 1'b1;
                            r_done   <= 1'b0;
                            r_chk_ok <= 1'b0;
                        end
                    end
                end
                S_HI: begin
                    if (Rx_Valid) begin
                        r_hi    <= Rx_Data;
                        r_acc   <= w_acc_next;
                        r_state <= S_LO;
                    end
                end
                S_LO: begin
                    // Leaving straight for HI lets the byte in the write cycle start the next word.
                    if (Rx_Valid) begin
                        r_acc     <= w_acc_next;
                        r_wr_en   <= 1'b1;
                        r_wr_data <= {r_hi, Rx_Data};
                        r_wr_addr <= r_cnt[ADDR_W-1:0];
                        r_cnt     <= w_cnt_next;
                        r_state   <= (w_cnt_next == r_n) ? S_CHK : S_HI;
                    end
                end
                S_CHK: begin
                    if (Rx_Valid) begin
                        r_chk_ok <= (w_acc_next == 8'h00);
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign Wr_En       = r_wr_en;
    assign Wr_Addr     = r_wr_addr;
    assign Wr_Data     = r_wr_data;
    assign Busy        = r_busy;
    assign Done        = r_done;
    assign Chk_Ok      = r_chk_ok;
    assign o_dbg_state = r_state;

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Byte-stream loader that fills the 2048x16 program memory before the CPU runs. It takes bytes from the serial receiver, assembles 16-bit instruction words (high byte first), and issues one write per word at sequential addresses from 0. A trailing XOR checksum byte is checked, and completion is reported to the top-level control.

Parameters:
ADDR_W, 11, program memory address width
DATA_W, 16, instruction word width
DEPTH, 2048, maximum words loadable (2**ADDR_W)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
Start  input  1  one-cycle pulse that begins a load; ignored while Busy=1
Word_Count  input  12  number of words to load; sampled on an accepted Start
Rx_Data  input  8  received byte
Rx_Valid  input  1  one-cycle strobe; Rx_Data is valid this cycle
Wr_En  output  1  program memory write strobe, one cycle per word
Wr_Addr  output  ADDR_W  program memory write address
Wr_Data  output  DATA_W  program memory write data
Busy  output  1  load in progress
Done  output  1  load finished; held until the next accepted Start or reset
Chk_Ok  output  1  checksum result; valid while Done=1

Behaviour:
- Reset (asynchronous, takes effect immediately): state IDLE; Wr_En=0, Wr_Addr=0, Wr_Data=0, Busy=0, Done=0, Chk_Ok=0; word counter=0; XOR accumulator=0.
- FSM states: IDLE, HI, LO, CHK, DONE.
- IDLE/DONE + Start: latch count N = min(Word_Count, 2048). Clear address, accumulator, Done and Chk_Ok. Go to HI with Busy=1 the next cycle.
  - If N=0: go straight to DONE with Done=1 and Chk_Ok=1; consume no bytes.
- Start while Busy=1: ignored, with no effect.
- HI + Rx_Valid: capture Rx_Data into word[15:8]; XOR it into the accumulator; go to LO.
- LO + Rx_Valid: capture Rx_Data into word[7:0]; XOR it into the accumulator.
  - Next cycle: Wr_En=1 for exactly one cycle, Wr_Data = assembled word, Wr_Addr = current address.
  - Address and word counter increment after the write cycle.
  - Next state is HI, or CHK once N words have been captured.
- No dead cycle between words: a byte on the cycle right after a low byte (the Wr_En cycle) is accepted as the next high byte. Back-to-back Rx_Valid every cycle must be supported.
- CHK + Rx_Valid: Chk_Ok = ((accumulator ^ Rx_Data) == 0). Go to DONE with Done=1 and Busy=0 on the next cycle.
- Bytes arriving while Rx_Valid=1 in IDLE or DONE are discarded.
- Wr_Addr holds its last written value between writes; after a full 2048-word load the last write is at 2047. The address never wraps, because N is capped at DEPTH.
- Word_Count > 2048 is clipped to 2048.
- A reset mid-load aborts immediately: the partially written memory is left as is, and no further Wr_En is issued.
- Wr_En is a registered output; Wr_Data and Wr_Addr are stable on every cycle where Wr_En=1.
- No timeout: an idle stream keeps the loader in HI, LO or CHK indefinitely.

Test Plan:
- Basic 4-word load:
  - Stimulus: Start with Word_Count=4, then bytes 60 00 63 01 6C 02 6C 47, then checksum 47.
  - Response: writes 0x6000@0, 0x6301@1, 0x6C02@2, 0x6C47@3; Done=1, Chk_Ok=1, Busy=0.
- Bad checksum: same stream with checksum 00 -> all 4 writes still occur; Done=1, Chk_Ok=0.
- Back-to-back: Rx_Valid high for 9 consecutive cycles (same bytes) -> exactly 4 single-cycle Wr_En pulses, 2 cycles apart; no byte lost.
- Boundaries:
  - Word_Count=0 -> Done=1, Chk_Ok=1, no Wr_En.
  - Word_Count=4095 -> exactly 2048 writes, last Wr_Addr=2047, then checksum accepted.
- Reset and restart:
  - Reset asserted after 3 bytes of a 4-word load -> all outputs return to reset values at once; no Wr_En after reset.
  - A new Start then loads again from address 0.
- Start handling:
  - Start pulsed in LO -> ignored; the load completes normally.
  - Start in DONE -> Done clears and a new load begins.
